// File: rtl/ctrl_step_sequencer_if.sv
// Handshake bundle between the run/stop controls, ctrl_unit and the step sequencer.
// The master side drives the control inputs; the slave side is the sequencer itself.
interface ctrl_step_sequencer_if #(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned CNT_W     = 16
);
    localparam int unsigned IDX_W = $clog2(NUM_STEPS);

    logic                 start;
    logic                 stop;
    logic                 end_instr;
    logic                 single_step;
    logic                 advance;
    logic [NUM_STEPS-1:0] step_onehot;
    logic [IDX_W-1:0]     step_idx;
    logic                 step_strobe;
    logic                 instr_done;
    logic [CNT_W-1:0]     instr_count;
    logic                 busy;
    logic                 halted;

    modport master (
        output start, stop, end_instr, single_step, advance,
        input  step_onehot, step_idx, step_strobe, instr_done, instr_count, busy, halted
    );

    modport slave (
        input  start, stop, end_instr, single_step, advance,
        output step_onehot, step_idx, step_strobe, instr_done, instr_count, busy, halted
    );
endinterface

// File: rtl/ctrl_step_sequencer.sv
// Control-step generator: one-hot T0..T(NUM_STEPS-1) with configurable dwell,
// early instruction end, stop/halt, single-step debug and retired-instruction count.
module ctrl_step_sequencer #(
    parameter int unsigned NUM_STEPS   = 8,
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    ctrl_step_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_STEPS);
    localparam int unsigned CYC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic                 end_pend_q, end_pend_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_STEPS-1:0] onehot_q, onehot_d;
    logic                 strobe_q, strobe_d;
    logic                 boundary;
    logic                 instr_end;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cyc_d      = cyc_q;
        end_pend_d = end_pend_q;
        count_d    = count_q;

        boundary  = (state_q == S_RUN) && (cyc_q == LAST_CYC) &&
                    (!bus.single_step || bus.advance);
        instr_end = boundary && (end_pend_q || bus.end_instr || (idx_q == LAST_IDX));

        unique case (state_q)
            S_IDLE, S_HALT: begin
                cyc_d = '0;
                idx_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = S_RUN;
                end else if (bus.start && (state_q == S_IDLE)) begin
                    state_d = S_HALT;
                end
            end
            S_RUN: begin
                if (bus.end_instr) begin
                    end_pend_d = 1'b1;
                end
                if (boundary) begin
                    cyc_d = '0;
                    if (instr_end) begin
                        count_d    = count_q + CNT_W'(1);
                        end_pend_d = 1'b0;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (bus.stop) begin
                        state_d = S_HALT;
                        idx_d   = '0;
                    end
                end else if (cyc_q != LAST_CYC) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        onehot_d = (state_d == S_RUN) ? (NUM_STEPS'(1) << idx_d) : '0;
        // Strobe marks step entry rather than cyc==0 so a held 1-cycle step strobes once.
        strobe_d = (state_d == S_RUN) && ((state_q != S_RUN) || boundary);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cyc_q      <= '0;
            end_pend_q <= 1'b0;
            count_q    <= '0;
            onehot_q   <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cyc_q      <= cyc_d;
            end_pend_q <= end_pend_d;
            count_q    <= count_d;
            onehot_q   <= onehot_d;
            strobe_q   <= strobe_d;
        end
    end

    assign bus.step_onehot = onehot_q;
    assign bus.step_idx    = idx_q;
    assign bus.step_strobe = strobe_q;
    // Same-cycle end_instr/advance decide whether this cycle ends the instruction.
    assign bus.instr_done  = instr_end;
    assign bus.instr_count = count_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.halted      = (state_q == S_HALT);
endmodule
